pwm_demod: RTL



---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_in_sync.sv | 26 ++
 rtl/pwm_demod.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, synchroniser depth and FSM state encoding for pwm_demod.
package pwm_pkg;
    localparam int SAMPLE_W_DEF     = 8;
    localparam int PERIOD_DEF       = 256;
    localparam int HUNT_TIMEOUT_DEF = 512;
    localparam int SYNC_DEPTH       = 2;
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        FREE = 2'd1,
        LOCK = 2'd2
    } state_e;
endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: metastability synchroniser plus delay flop and rising-edge detect.
module pwm_in_sync
    import pwm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_o
);
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  dly_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pwm_i};
            dly_q  <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign pwm_s_o = sync_q[SYNC_DEPTH-1];
    assign rise_o  = sync_q[SYNC_DEPTH-1] & ~dly_q;
endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers one PWM duty-cycle sample per frame with edge-based frame alignment.
// Define PWM_DEMOD_AVG_EN to report the rounded mean of consecutive frame totals.
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int SAMPLE_W     = SAMPLE_W_DEF,
    parameter int PERIOD       = PERIOD_DEF,
    parameter int HUNT_TIMEOUT = HUNT_TIMEOUT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pwm_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                locked,
    output logic                sync_err
);
    localparam int                TW         = $clog2(HUNT_TIMEOUT);
    localparam logic [SAMPLE_W-1:0] FRAME_LAST = SAMPLE_W'(PERIOD - 1);
    localparam logic [TW-1:0]     TMO_LAST   = TW'(HUNT_TIMEOUT - 1);
    localparam logic [SAMPLE_W:0] SAT_MAX    = {1'b0, {SAMPLE_W{1'b1}}};

    logic                pwm_s, rise;
    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] frame_q, frame_d, sample_q, sample_d, sat;
    logic [SAMPLE_W:0]   high_q, high_d, total;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                valid_q, err_q, err_d, emit, realign;

    pwm_in_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .pwm_i  (pwm_in),
        .pwm_s_o(pwm_s),
        .rise_o (rise)
    );

    always_comb begin
        // a rise on the last frame cycle opens the next frame, so it is not counted here
        total   = high_q + {{SAMPLE_W{1'b0}}, pwm_s & ~rise};
        sat     = (total > SAT_MAX) ? SAT_MAX[SAMPLE_W-1:0] : total[SAMPLE_W-1:0];
        state_d = state_q;
        frame_d = frame_q + 1'b1;
        high_d  = high_q + {{SAMPLE_W{1'b0}}, pwm_s};
        tmo_d   = '0;
        emit    = 1'b0;
        realign = 1'b0;
        err_d   = 1'b0;
        if (state_q == HUNT) begin
            frame_d = '0;
            high_d  = '0;
            tmo_d   = tmo_q + 1'b1;
            if (rise) begin
                realign = 1'b1;
                state_d = LOCK;
            end else if (tmo_q == TMO_LAST) begin
                state_d = FREE;
            end
        end else begin
            emit = (frame_q == FRAME_LAST);
            if (emit) begin
                frame_d = '0;
                high_d  = '0;
            end
            if (rise && (state_q == FREE || frame_q != '0)) begin
                realign = 1'b1;
                err_d   = (state_q == LOCK) && !emit;
                state_d = LOCK;
            end
        end
        if (realign) begin
            frame_d = SAMPLE_W'(1);
            high_d  = (SAMPLE_W+1)'(1);
        end
    end

`ifdef PWM_DEMOD_AVG_EN
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [SAMPLE_W:0]   avg_sum;

    always_comb begin
        avg_sum    = {1'b0, prev_q} + {1'b0, sat} + 1'b1;
        sample_d   = emit ? (prev_vld_q ? SAMPLE_W'(avg_sum >> 1) : sat) : sample_q;
        prev_d     = emit ? sat : prev_q;
        prev_vld_d = emit | prev_vld_q;
        if (realign) begin
            prev_d     = '0;
            prev_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    assign sample_d = emit ? sat : sample_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            frame_q  <= '0;
            high_q   <= '0;
            tmo_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            high_q   <= high_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            valid_q  <= emit;
            err_q    <= err_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign locked       = (state_q == LOCK);
    assign sync_err     = err_q;
endmodule
